// File: rtl/gpio_in_filter.sv
// gpio_in_filter: 32-pin GPIO input conditioning.
// Each pad passes through a 2-flop synchroniser.
// With GPIO_DBNC_FILTER_EN defined, a per-pin counter debounce is compiled in.
// The debounce is clocked by a shared prescaler tick.
// Without the macro every pin is synchronised and registered only.
// In that build the debounce configuration inputs are ignored and dbnc_tick is tied low.
module gpio_in_filter (
    input  logic        mclk,
    input  logic        h_reset_n,
    input  logic [31:0] pad_gpio_in,
    input  logic [31:0] cfg_gpio_dbnc_en,
    input  logic [15:0] cfg_dbnc_prescale,
    input  logic [2:0]  cfg_dbnc_cnt,
    output logic [31:0] cfg_gpio_data_in,
    output logic [31:0] gpio_prev_indata,
    output logic        dbnc_tick
);

    localparam int unsigned NumPins = 32;

    logic [NumPins-1:0] sync1_q, sync1_d;
    logic [NumPins-1:0] sync2_q, sync2_d;
    logic [NumPins-1:0] data_q, data_d;
    logic [NumPins-1:0] prev_q, prev_d;

    // Synchroniser chain and one-cycle-delayed copy of the conditioned levels
    always_comb begin
        sync1_d = pad_gpio_in;
        sync2_d = sync1_q;
        prev_d  = data_q;
    end

    // Pin data registers; synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            data_q  <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            data_q  <= data_d;
            prev_q  <= prev_d;
        end
    end

`ifdef GPIO_DBNC_FILTER_EN

    logic [15:0]             presc_q, presc_d;
    logic                    tick;
    logic [2:0]              cnt_lim;
    logic [NumPins-1:0][2:0] cnt_q, cnt_d;

    // Prescaler.
    // A count above a newly lowered limit wraps to 0 without a tick.
    // The tick is masked while reset is held.
    always_comb begin
        tick    = h_reset_n && (presc_q == cfg_dbnc_prescale);
        presc_d = (presc_q >= cfg_dbnc_prescale) ? 16'd0 : presc_q + 16'd1;
    end

    // Acceptance threshold N-1; a configured count of 0 behaves like 1
    always_comb begin
        cnt_lim = (cfg_dbnc_cnt == 3'd0) ? 3'd0 : cfg_dbnc_cnt - 3'd1;
    end

    // Per-pin debounce: count ticks while sync2 disagrees with the accepted level
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NumPins; i++) begin
            if (!cfg_gpio_dbnc_en[i]) begin
                data_d[i] = sync2_q[i];
                cnt_d[i]  = 3'd0;
            end else if (sync2_q[i] == data_q[i]) begin
                cnt_d[i] = 3'd0;
            end else if (tick) begin
                // >= also covers a threshold lowered mid-count, keeping cnt <= 6
                if (cnt_q[i] >= cnt_lim) begin
                    data_d[i] = sync2_q[i];
                    cnt_d[i]  = 3'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Prescaler and counter state
    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbnc_tick = tick;

`else

    logic unused_cfg;

    // Filter compiled out: every pin registers its synchronised level
    always_comb begin
        data_d = sync2_q;
    end

    assign unused_cfg = ^{cfg_gpio_dbnc_en, cfg_dbnc_prescale, cfg_dbnc_cnt};
    assign dbnc_tick  = 1'b0;

`endif

    assign cfg_gpio_data_in = data_q;
    assign gpio_prev_indata = prev_q;

endmodule

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 mclk  input  1  system clock; sole clock of the block.
REQ-002 h_reset_n  input  1  system reset; synchronous to mclk, active-low.
REQ-003 pad_gpio_in  input  32  asynchronous GPIO pad input levels.
REQ-004 cfg_gpio_dbnc_en  input  32  per-pin debounce enable (1 = filtered, 0 = synchronised only).
REQ-005 cfg_dbnc_prescale  input  16  sample-tick divider; tick period is cfg_dbnc_prescale+1 mclk cycles.
REQ-006 cfg_dbnc_cnt  input  3  stable sample ticks required before a level is accepted; 0 treated as 1.
REQ-007 cfg_gpio_data_in  output  32  conditioned pin levels, for the interrupt-edge stage and the config read path.
REQ-008 gpio_prev_indata  output  32  cfg_gpio_data_in delayed by one mclk cycle.
REQ-009 dbnc_tick  output  1  one-cycle pulse per prescaler sample tick (status/test only).

Function
REQ-010 Each pin SHALL pass through a 2-flop synchroniser (sync1, sync2): pad change sampled at edge k appears on sync2 after edge k+1.
REQ-011 Prescaler SHALL count 0..cfg_dbnc_prescale, assert dbnc_tick in the cycle it equals cfg_dbnc_prescale, then return to 0 on the next edge.
REQ-012 cfg_dbnc_prescale=0 SHALL assert dbnc_tick every cycle.
REQ-013 Prescaler value greater than a newly written cfg_dbnc_prescale SHALL wrap to 0 on the next edge with no tick.
REQ-014 Pin with debounce disabled: cfg_gpio_data_in[i] SHALL register sync2[i] each edge; pad-to-output latency is 3 edges.
REQ-015 Pin with debounce enabled: 3-bit counter cnt[i] SHALL clear to 0 in any cycle where sync2[i] equals cfg_gpio_data_in[i].
REQ-016 If sync2[i] differs and dbnc_tick=1: when cnt[i] = N-1 (N = effective cfg_dbnc_cnt), cfg_gpio_data_in[i] SHALL take sync2[i] and cnt[i] SHALL clear; otherwise cnt[i] SHALL increment.
REQ-017 If sync2[i] differs and dbnc_tick=0, cnt[i] SHALL hold.
REQ-018 A glitch that returns to the accepted level before N ticks SHALL leave cfg_gpio_data_in unchanged and SHALL clear cnt[i].
REQ-019 cnt[i] SHALL never exceed 6; no wrap-around is possible because acceptance occurs at N-1 <= 6.
REQ-020 Clearing cfg_gpio_dbnc_en[i] mid-count SHALL clear cnt[i] and revert the pin to REQ-014 behaviour on the next edge.
REQ-021 gpio_prev_indata SHALL register cfg_gpio_data_in every edge, unconditionally.
REQ-022 Outputs SHALL be registered; no combinational path from pad_gpio_in to any output.
REQ-023 Pins SHALL be fully independent apart from the shared prescaler tick.

Reset
REQ-024 When h_reset_n=0 at an mclk edge: sync1, sync2, cfg_gpio_data_in, gpio_prev_indata, all cnt and the prescaler SHALL be 0; dbnc_tick SHALL be 0.
REQ-025 Reset asserted mid-count SHALL discard the partial count; the first tick after release occurs cfg_dbnc_prescale+1 cycles after release.
REQ-026 No spurious edge SHALL appear after reset: gpio_prev_indata equals cfg_gpio_data_in (both 0) in the first cycle after release.

Configuration
REQ-027 Macro GPIO_DBNC_FILTER_EN defined: the prescaler, counters and REQ-015..REQ-020 SHALL be compiled in.
REQ-028 Macro absent: every pin SHALL behave per REQ-014; cfg_gpio_dbnc_en, cfg_dbnc_prescale and cfg_dbnc_cnt SHALL be ignored; dbnc_tick SHALL be tied 0; ports are unchanged.

Verification
REQ-029 Reset with pad_gpio_in=32'hFFFF_FFFF -> both outputs 0 during reset; cfg_gpio_data_in=32'hFFFF_FFFF at the 3rd edge after release; gpio_prev_indata follows one edge later.
REQ-030 dbnc_en=0, pin 5 rises at edge k -> cfg_gpio_data_in[5]=1 after edge k+2 and gpio_prev_indata[5]=1 after edge k+3; a downstream posedge detect sees exactly one cycle with prev=0, data=1.
REQ-031 dbnc_en[0]=1, prescale=3, cnt=4, pin 0 held high -> dbnc_tick every 4 cycles; output rises on the 4th tick after sync2 changes; neighbouring pins unaffected.
REQ-032 Same config, pin 0 high-pulse lasting 2 ticks -> cfg_gpio_data_in[0] stays 0 and cnt[0] returns to 0.
REQ-033 cnt=0 versus cnt=1 with prescale=0 -> identical behaviour: each accepts the new level on the first differing cycle.
REQ-034 h_reset_n pulsed low for 1 cycle mid-count (cnt[0]=2) -> cnt cleared, output 0, and full re-qualification of N ticks required; repeat the suite with the macro undefined and confirm REQ-028.
